fetch_ctrl: RTL

Instruction-fetch sequencer for the STRV32I core. It owns the architectural PC register and drives `pc_unit` through `pc_src`, `branch_take` and `iaddr`, loading the PC from `pc_unit`'s next-PC mux output. It also runs a request/grant/response handshake with instruction memory and presents one fetched instruction at a time to decode, with a valid/ready handshake. Branch/jump redirects and pipeline stalls from execute are resolved here.

---
 rtl/fetch_ctrl_if.sv | 44 ++++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: signal bundle between the fetch sequencer and pc_unit, instruction memory, decode and execute
//   master: fetch_ctrl side (drives pc/pc_unit controls, imem request, decode instruction)
//   slave:  environment side (drives stall/redirect, pc_unit next-PC, imem grant/response, decode ready)
//   misalign_out exists only when FETCH_MISALIGN_TRAP_EN is defined
interface fetch_ctrl_if;
  logic stall_in;
  logic redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic [31:0] pc_mux_in;
  logic [31:0] pc_out;
  logic [1:0] pc_src_out;
  logic branch_take_out;
  logic [30:0] iaddr_out;
  logic imem_req_out;
  logic [31:0] imem_addr_out;
  logic imem_gnt_in;
  logic imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic instr_ready_in;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_out;
`endif
  modport master(
`ifdef FETCH_MISALIGN_TRAP_EN
    output misalign_out,
`endif
    input stall_in, redirect_valid_in, redirect_addr_in, pc_mux_in,
    input imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
    output pc_out, pc_src_out, branch_take_out, iaddr_out,
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out
  );
  modport slave(
`ifdef FETCH_MISALIGN_TRAP_EN
    input misalign_out,
`endif
    output stall_in, redirect_valid_in, redirect_addr_in, pc_mux_in,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
    input pc_out, pc_src_out, branch_take_out, iaddr_out,
    input imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: STRV32I instruction-fetch sequencer (PC register, imem req/gnt/rvalid, one-entry decode buffer)
//   clk_in, rst_n_in (async active-low); bus: fetch_ctrl_if.master
//   BOOT_ADDR: PC after reset
//   FETCH_MISALIGN_TRAP_EN: redirect with target bit 1 set raises sticky misalign_out and halts fetch
module fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic clk_in,
  input logic rst_n_in,
  fetch_ctrl_if.master bus
);
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {BOOT, FETCH, WAIT, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} state_t;
`endif
  state_t state, state_d;
  logic [31:0] pc, pc_d, instr, instr_pc;
  logic kill, kill_d, valid, valid_d, cap, req, acc, redir;
  assign req = state == FETCH && !bus.stall_in;
  assign acc = req && bus.imem_gnt_in;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign, trap;
  assign redir = bus.redirect_valid_in && state != BOOT && state != HALT;
  assign trap = redir && bus.redirect_addr_in[1];
`else
  assign redir = bus.redirect_valid_in && state != BOOT;
`endif
  // kill marks a granted request whose response must be dropped after a redirect
  always_comb begin
    state_d = state;
    pc_d = redir ? bus.pc_mux_in : pc;
    kill_d = kill;
    valid_d = valid;
    cap = 1'b0;
    case (state)
      BOOT: state_d = FETCH;
      FETCH: begin
        state_d = acc ? WAIT : FETCH;
        kill_d = acc && redir;
      end
      WAIT:
        if (bus.imem_rvalid_in) begin
          cap = !(kill || redir);
          valid_d = !(kill || redir);
          state_d = (kill || redir) ? FETCH : HOLD;
          kill_d = 1'b0;
        end else
          kill_d = kill || redir;
      HOLD:
        if (redir || (bus.instr_ready_in && !bus.stall_in)) begin
          state_d = FETCH;
          valid_d = 1'b0;
          pc_d = bus.pc_mux_in;
        end
      default: ;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (trap) begin
      state_d = HALT;
      valid_d = 1'b0;
      kill_d = 1'b0;
      cap = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= BOOT;
      pc <= BOOT_ADDR;
      kill <= 1'b0;
      valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      kill <= kill_d;
      valid <= valid_d;
      if (cap) begin
        instr <= bus.imem_rdata_in;
        instr_pc <= pc;
      end
    end
`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) misalign <= 1'b0;
    else if (trap) misalign <= 1'b1;
  assign bus.misalign_out = misalign;
`endif
  assign bus.pc_out = pc;
  assign bus.pc_src_out = state == BOOT ? 2'b00 : 2'b11;
  assign bus.branch_take_out = bus.redirect_valid_in;
  assign bus.iaddr_out = bus.redirect_addr_in[31:1];
  assign bus.imem_req_out = req;
  assign bus.imem_addr_out = pc;
  assign bus.instr_valid_out = valid;
  assign bus.instr_out = instr;
  assign bus.instr_pc_out = instr_pc;
endmodule
